// File: rtl/crosspoint_switch_model.sv
`default_nettype none
// ============================================================================
// Module      : crosspoint_switch_model
// Description : Pin-level responder for a 16x8 analog crosspoint switch.
//               Synchronizes the RESET/CS/AX/AY/STROBE/DATA pins, decodes
//               strobed writes into a 128-bit on/off matrix, and keeps sticky
//               protocol-violation flags plus a commit counter and readback.
// Revision    : 1.0 - initial release
// ============================================================================
module crosspoint_switch_model #(
  parameter int SYNC_STAGES       = 2,
  parameter int MIN_STROBE_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         sw_reset,
  input  logic         sw_cs,
  input  logic [3:0]   sw_ax,
  input  logic [2:0]   sw_ay,
  input  logic         sw_strobe,
  input  logic         sw_data,
  input  logic [3:0]   rd_ax,
  input  logic [2:0]   rd_ay,
  output logic         rd_on,
  output logic [127:0] xpt_state,
  output logic         upd_valid,
  output logic [6:0]   upd_addr,
  output logic         upd_data,
  output logic [15:0]  write_count,
  output logic [2:0]   err_flags,
  input  logic         err_clear
);

  // Pin bundle layout: {reset, cs, ax[3:0], ay[2:0], strobe, data}
  localparam int C_PIN_W = 11;
  // Width counter only needs to reach MIN_STROBE_CYCLES (it saturates there)
  localparam int C_WW = $clog2(MIN_STROBE_CYCLES + 1);
  localparam logic [C_WW-1:0] C_MIN = C_WW'(MIN_STROBE_CYCLES);
  localparam logic [C_WW-1:0] C_ONE = C_WW'(1);

  // Error flag bit positions inside err_flags
  localparam int C_ERR_NO_CS = 0;
  localparam int C_ERR_SETUP = 1;
  localparam int C_ERR_SHORT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [C_PIN_W-1:0] w_pins;
  logic [C_PIN_W-1:0] r_sync [SYNC_STAGES];
  logic [C_PIN_W-1:0] w_s;

  logic               w_s_rst;
  logic               w_s_cs;
  logic [3:0]         w_s_ax;
  logic [2:0]         w_s_ay;
  logic               w_s_strobe;
  logic               w_s_data;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_strobe_prev;
  logic [3:0]         r_cap_ax;
  logic [2:0]         r_cap_ay;
  logic               r_cap_data;
  logic [C_WW-1:0]    r_width;
  logic               r_valid;

  logic               w_cap_en;
  logic [C_WW-1:0]    w_width_next;
  logic               w_valid_next;
  logic [2:0]         w_err_new;
  logic               w_commit;
  logic [6:0]         w_cap_idx;

  logic [127:0]       r_xpt;
  logic               r_rd_on;
  logic               r_upd_valid;
  logic [6:0]         r_upd_addr;
  logic               r_upd_data;
  logic [15:0]        r_write_count;
  logic [2:0]         r_err;

  // --------------------------------------------------------------------------
  // Pin synchronizers
  // --------------------------------------------------------------------------
  assign w_pins = {sw_reset, sw_cs, sw_ax, sw_ay, sw_strobe, sw_data};

  // Shift every pin through the same number of stages so that address, data
  // and strobe stay aligned relative to each other after synchronization.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_s_rst    = w_s[10];
  assign w_s_cs     = w_s[9];
  assign w_s_ax     = w_s[8:5];
  assign w_s_ay     = w_s[4:2];
  assign w_s_strobe = w_s[1];
  assign w_s_data   = w_s[0];

  assign w_cap_idx  = {r_cap_ax, r_cap_ay};

  // --------------------------------------------------------------------------
  // Write-decode FSM
  // --------------------------------------------------------------------------

  // FSM state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: strobe edge detection, width tracking, error detection
  always_comb begin
    w_state_next = r_state;
    w_cap_en     = 1'b0;
    w_width_next = r_width;
    w_valid_next = r_valid;
    w_err_new    = 3'b000;
    w_commit     = 1'b0;

    if (w_s_rst) begin
      // Device reset aborts any write silently and ignores strobe activity
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_s_strobe && !r_strobe_prev) begin
            if (w_s_cs) begin
              w_state_next = ST_HIGH;
              w_cap_en     = 1'b1;
              w_width_next = C_ONE;
              w_valid_next = 1'b1;
            end else begin
              w_err_new[C_ERR_NO_CS] = 1'b1;
            end
          end
        end

        ST_HIGH: begin
          if (w_s_strobe) begin
            if (r_width < C_MIN) begin
              w_width_next = r_width + C_ONE;
            end
            // Address/data must be held, and CS kept, for the whole pulse
            if ((w_s_ax != r_cap_ax) || (w_s_ay != r_cap_ay) ||
                (w_s_data != r_cap_data) || !w_s_cs) begin
              w_err_new[C_ERR_SETUP] = 1'b1;
              w_valid_next           = 1'b0;
            end
          end else begin
            if ((r_width >= C_MIN) && r_valid) begin
              w_state_next = ST_COMMIT;
            end else begin
              if (r_width < C_MIN) begin
                w_err_new[C_ERR_SHORT] = 1'b1;
              end
              w_state_next = ST_IDLE;
            end
          end
        end

        ST_COMMIT: begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Capture of address/data at strobe rise plus width/validity tracking
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cap_ax   <= '0;
      r_cap_ay   <= '0;
      r_cap_data <= 1'b0;
      r_width    <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_cap_en) begin
        r_cap_ax   <= w_s_ax;
        r_cap_ay   <= w_s_ay;
        r_cap_data <= w_s_data;
      end
      r_width <= w_width_next;
      r_valid <= w_valid_next;
    end
  end

  // --------------------------------------------------------------------------
  // Matrix, update reporting, counters and error flags
  // --------------------------------------------------------------------------

  // Matrix update on commit, device-reset clear, and update/commit reporting
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_strobe_prev <= 1'b0;
      r_xpt         <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_addr    <= '0;
      r_upd_data    <= 1'b0;
      r_write_count <= '0;
    end else begin
      // Tracked even during device reset so a strobe held across its
      // release is not mistaken for a fresh rising edge.
      r_strobe_prev <= w_s_strobe;
      r_upd_valid   <= 1'b0;
      if (w_s_rst) begin
        r_xpt <= '0;
      end else if (w_commit) begin
        r_xpt[w_cap_idx] <= r_cap_data;
        r_upd_valid      <= 1'b1;
        r_upd_addr       <= w_cap_idx;
        r_upd_data       <= r_cap_data;
        r_write_count    <= r_write_count + 16'd1;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle survives the clear
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err <= (r_err & ~{3{err_clear}}) | w_err_new;
    end
  end

  // Registered single-cell readback of the committed matrix
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rd_on <= 1'b0;
    end else begin
      r_rd_on <= r_xpt[{rd_ax, rd_ay}];
    end
  end

  assign rd_on       = r_rd_on;
  assign xpt_state   = r_xpt;
  assign upd_valid   = r_upd_valid;
  assign upd_addr    = r_upd_addr;
  assign upd_data    = r_upd_data;
  assign write_count = r_write_count;
  assign err_flags   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_crosspoint_switch_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_crosspoint_switch_model
// Description : Self-checking bench for crosspoint_switch_model. Drives
//               pin-level write transactions and compares against a
//               transaction-level model of the switch matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crosspoint_switch_model;

  localparam int SYNC = 2;
  localparam int MINW = 4;

  logic         CLK;
  logic         reset;
  logic         sw_reset;
  logic         sw_cs;
  logic [3:0]   sw_ax;
  logic [2:0]   sw_ay;
  logic         sw_strobe;
  logic         sw_data;
  logic [3:0]   rd_ax;
  logic [2:0]   rd_ay;
  logic         rd_on;
  logic [127:0] xpt_state;
  logic         upd_valid;
  logic [6:0]   upd_addr;
  logic         upd_data;
  logic [15:0]  write_count;
  logic [2:0]   err_flags;
  logic         err_clear;

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference model
  logic [127:0] m_xpt;
  logic [15:0]  m_count;
  logic [2:0]   m_err;
  logic [6:0]   m_addr;
  logic         m_data;

  crosspoint_switch_model #(
    .SYNC_STAGES       (SYNC),
    .MIN_STROBE_CYCLES (MINW)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .sw_reset    (sw_reset),
    .sw_cs       (sw_cs),
    .sw_ax       (sw_ax),
    .sw_ay       (sw_ay),
    .sw_strobe   (sw_strobe),
    .sw_data     (sw_data),
    .rd_ax       (rd_ax),
    .rd_ay       (rd_ay),
    .rd_on       (rd_on),
    .xpt_state   (xpt_state),
    .upd_valid   (upd_valid),
    .upd_addr    (upd_addr),
    .upd_data    (upd_data),
    .write_count (write_count),
    .err_flags   (err_flags),
    .err_clear   (err_clear)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model of one transaction's effect, from the protocol rules
  task automatic model_txn(input logic [3:0] ax, input logic [2:0] ay, input logic d,
                           input logic cs, input int width, input int glitch,
                           output int exp_pulses);
    exp_pulses = 0;
    if (!cs) begin
      m_err[0] = 1'b1;
    end else begin
      if (glitch != 0) m_err[1] = 1'b1;
      if (width < MINW) m_err[2] = 1'b1;
      if (glitch == 0 && width >= MINW) begin
        m_xpt[ax * 8 + ay] = d;
        m_count = m_count + 16'd1;
        m_addr = {ax, ay};
        m_data = d;
        exp_pulses = 1;
      end
    end
  endtask

  // Pin-level write: setup, strobe for 'width' clocks, optional mid-pulse
  // disturbance, then an idle window counting upd_valid pulses. lat is the
  // number of clock edges from strobe-fall to the first upd_valid.
  task automatic do_txn(input logic [3:0] ax, input logic [2:0] ay, input logic d,
                        input logic cs, input int width, input int glitch,
                        output int pulses, output int lat);
    @(posedge CLK); #1;
    sw_ax = ax; sw_ay = ay; sw_data = d; sw_cs = cs;
    @(posedge CLK); #1;
    sw_strobe = 1'b1;
    for (int i = 0; i < width; i++) begin
      if (i == 1) begin
        case (glitch)
          1: sw_ax = ax + 4'd1;
          2: sw_data = ~d;
          3: sw_cs = 1'b0;
          default: ;
        endcase
      end
      @(posedge CLK); #1;
    end
    sw_strobe = 1'b0;
    pulses = 0;
    lat = 0;
    for (int k = 1; k <= SYNC + 6; k++) begin
      @(negedge CLK);
      if (upd_valid === 1'b1) begin
        pulses++;
        if (lat == 0) lat = k - 1;
      end
    end
  endtask

  task automatic pulse_err_clear();
    @(posedge CLK); #1;
    err_clear = 1'b1;
    @(posedge CLK); #1;
    err_clear = 1'b0;
    m_err = 3'b000;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_reset = 1'b0; sw_cs = 1'b0; sw_ax = '0; sw_ay = '0;
    sw_strobe = 1'b0; sw_data = 1'b0; rd_ax = '0; rd_ay = '0; err_clear = 1'b0;
    m_xpt = '0; m_count = '0; m_err = '0; m_addr = '0; m_data = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    checks++; if (xpt_state !== 128'd0) begin failures++; $display("FAIL rst_xpt: got %h exp 0", xpt_state); end
    checks++; if (rd_on !== 1'b0) begin failures++; $display("FAIL rst_rd_on: got %b exp 0", rd_on); end
    checks++; if (upd_valid !== 1'b0) begin failures++; $display("FAIL rst_upd_valid: got %b exp 0", upd_valid); end
    checks++; if (upd_addr !== 7'd0 || upd_data !== 1'b0) begin failures++; $display("FAIL rst_upd: got %h/%b exp 0/0", upd_addr, upd_data); end
    checks++; if (write_count !== 16'd0) begin failures++; $display("FAIL rst_count: got %h exp 0", write_count); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL rst_err: got %b exp 000", err_flags); end
  endtask

  task automatic test_basic_write();
    int p, l, ep;
    model_txn(4'd5, 3'd3, 1'b1, 1'b1, 6, 0, ep);
    do_txn(4'd5, 3'd3, 1'b1, 1'b1, 6, 0, p, l);
    checks++; if (p !== 1) begin failures++; $display("FAIL basic_pulses: got %0d exp 1", p); end
    checks++; if (l !== SYNC + 2) begin failures++; $display("FAIL basic_latency: got %0d exp %0d", l, SYNC + 2); end
    checks++; if (xpt_state[43] !== 1'b1 || xpt_state !== m_xpt) begin failures++; $display("FAIL basic_xpt: got %h exp %h", xpt_state, m_xpt); end
    checks++; if (upd_addr !== 7'h2B || upd_data !== 1'b1) begin failures++; $display("FAIL basic_upd: got %h/%b exp 2b/1", upd_addr, upd_data); end
    checks++; if (write_count !== 16'd1) begin failures++; $display("FAIL basic_count: got %h exp 1", write_count); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL basic_err: got %b exp 000", err_flags); end
  endtask

  task automatic test_short_strobe();
    int p, l, ep;
    model_txn(4'd1, 3'd0, 1'b1, 1'b1, 2, 0, ep);
    do_txn(4'd1, 3'd0, 1'b1, 1'b1, 2, 0, p, l);
    checks++; if (p !== 0) begin failures++; $display("FAIL short_pulses: got %0d exp 0", p); end
    checks++; if (xpt_state !== m_xpt) begin failures++; $display("FAIL short_xpt: got %h exp %h", xpt_state, m_xpt); end
    checks++; if (err_flags !== 3'b100) begin failures++; $display("FAIL short_err: got %b exp 100", err_flags); end
    checks++; if (write_count !== 16'd1) begin failures++; $display("FAIL short_count: got %h exp 1", write_count); end
    pulse_err_clear();
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL short_clear: got %b exp 000", err_flags); end
    // One below and exactly at the minimum width
    model_txn(4'd1, 3'd1, 1'b1, 1'b1, MINW - 1, 0, ep);
    do_txn(4'd1, 3'd1, 1'b1, 1'b1, MINW - 1, 0, p, l);
    checks++; if (p !== 0 || err_flags !== 3'b100) begin failures++; $display("FAIL minus1_width: got p=%0d err=%b exp p=0 err=100", p, err_flags); end
    pulse_err_clear();
    model_txn(4'd1, 3'd1, 1'b1, 1'b1, MINW, 0, ep);
    do_txn(4'd1, 3'd1, 1'b1, 1'b1, MINW, 0, p, l);
    checks++; if (p !== 1 || err_flags !== 3'b000 || xpt_state !== m_xpt) begin failures++; $display("FAIL exact_width: got p=%0d err=%b xpt=%h exp p=1 err=000 xpt=%h", p, err_flags, xpt_state, m_xpt); end
  endtask

  task automatic test_cs_and_setup();
    int p, l, ep;
    model_txn(4'd7, 3'd2, 1'b1, 1'b0, 5, 0, ep);
    do_txn(4'd7, 3'd2, 1'b1, 1'b0, 5, 0, p, l);
    checks++; if (p !== 0 || err_flags !== 3'b001) begin failures++; $display("FAIL no_cs: got p=%0d err=%b exp p=0 err=001", p, err_flags); end
    pulse_err_clear();
    model_txn(4'd5, 3'd1, 1'b1, 1'b1, 6, 1, ep);
    do_txn(4'd5, 3'd1, 1'b1, 1'b1, 6, 1, p, l);
    checks++; if (p !== 0 || err_flags !== 3'b010) begin failures++; $display("FAIL setup_ax: got p=%0d err=%b exp p=0 err=010", p, err_flags); end
    checks++; if (xpt_state !== m_xpt || write_count !== m_count) begin failures++; $display("FAIL setup_nowrite: got %h/%h exp %h/%h", xpt_state, write_count, m_xpt, m_count); end
    // Error raised in the very cycle err_clear is high must survive it,
    // while the older short-strobe flag is cleared.
    model_txn(4'd0, 3'd0, 1'b1, 1'b1, 2, 0, ep);
    do_txn(4'd0, 3'd0, 1'b1, 1'b1, 2, 0, p, l);
    pulse_err_clear();
    model_txn(4'd0, 3'd0, 1'b1, 1'b1, 2, 0, ep);
    do_txn(4'd0, 3'd0, 1'b1, 1'b1, 2, 0, p, l);
    @(posedge CLK); #1;
    sw_cs = 1'b0;
    sw_strobe = 1'b1;
    repeat (SYNC) @(posedge CLK);
    #1 err_clear = 1'b1;
    @(posedge CLK); #1;
    err_clear = 1'b0;
    sw_strobe = 1'b0;
    m_err = 3'b001;
    repeat (SYNC + 3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (err_flags !== m_err) begin failures++; $display("FAIL clear_vs_err: got %b exp %b", err_flags, m_err); end
    pulse_err_clear();
  endtask

  task automatic test_random();
    int p, l, ep, width, glitch;
    logic [3:0] ax;
    logic [2:0] ay;
    logic d, cs;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) pulse_err_clear();
      ax = 4'($urandom_range(0, 15));
      ay = 3'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 1));
      cs = ($urandom_range(0, 5) != 0);
      width = $urandom_range(1, 7);
      glitch = (cs && width >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      rd_ax = 4'($urandom_range(0, 15));
      rd_ay = 3'($urandom_range(0, 7));
      model_txn(ax, ay, d, cs, width, glitch, ep);
      do_txn(ax, ay, d, cs, width, glitch, p, l);
      checks++; if (p !== ep) begin failures++; $display("FAIL rnd_pulses[%0d]: got %0d exp %0d", n, p, ep); end
      checks++; if (xpt_state !== m_xpt) begin failures++; $display("FAIL rnd_xpt[%0d]: got %h exp %h", n, xpt_state, m_xpt); end
      checks++; if (write_count !== m_count) begin failures++; $display("FAIL rnd_count[%0d]: got %h exp %h", n, write_count, m_count); end
      checks++; if (err_flags !== m_err) begin failures++; $display("FAIL rnd_err[%0d]: got %b exp %b", n, err_flags, m_err); end
      checks++; if (upd_addr !== m_addr || upd_data !== m_data) begin failures++; $display("FAIL rnd_upd[%0d]: got %h/%b exp %h/%b", n, upd_addr, upd_data, m_addr, m_data); end
      checks++; if (rd_on !== m_xpt[rd_ax * 8 + rd_ay]) begin failures++; $display("FAIL rnd_rd_on[%0d]: got %b exp %b", n, rd_on, m_xpt[rd_ax * 8 + rd_ay]); end
    end
    pulse_err_clear();
  endtask

  task automatic test_sw_reset();
    int p, l, ep, pulses;
    logic [6:0] idx;
    for (int c = 0; c < 128; c++) begin
      idx = 7'(c);
      model_txn(idx[6:3], idx[2:0], 1'b1, 1'b1, MINW, 0, ep);
      do_txn(idx[6:3], idx[2:0], 1'b1, 1'b1, MINW, 0, p, l);
    end
    checks++; if (xpt_state !== {128{1'b1}}) begin failures++; $display("FAIL fill_xpt: got %h exp all ones", xpt_state); end
    @(posedge CLK); #1;
    sw_reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 sw_reset = 1'b0;
    m_xpt = '0;
    repeat (SYNC + 2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (xpt_state !== 128'd0) begin failures++; $display("FAIL swrst_xpt: got %h exp 0", xpt_state); end
    checks++; if (write_count !== m_count) begin failures++; $display("FAIL swrst_count: got %h exp %h", write_count, m_count); end
    checks++; if (upd_addr !== m_addr || err_flags !== m_err) begin failures++; $display("FAIL swrst_kept: got %h/%b exp %h/%b", upd_addr, err_flags, m_addr, m_err); end
    // Device reset arriving in the middle of a valid strobe aborts it
    @(posedge CLK); #1;
    sw_ax = 4'd2; sw_ay = 3'd2; sw_data = 1'b1; sw_cs = 1'b1;
    @(posedge CLK); #1;
    sw_strobe = 1'b1;
    repeat (2) @(posedge CLK);
    #1 sw_reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 sw_reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1 sw_strobe = 1'b0;
    // A whole strobe pulse while device reset is held is ignored
    repeat (2) @(posedge CLK);
    #1 sw_reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 sw_strobe = 1'b1;
    repeat (5) @(posedge CLK);
    #1 sw_strobe = 1'b0;
    repeat (2) @(posedge CLK);
    #1 sw_reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < SYNC + 6; k++) begin
      @(negedge CLK);
      if (upd_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || xpt_state !== 128'd0) begin failures++; $display("FAIL swrst_abort: got p=%0d xpt=%h exp p=0 xpt=0", pulses, xpt_state); end
    checks++; if (write_count !== m_count || err_flags !== m_err) begin failures++; $display("FAIL swrst_abort_state: got %h/%b exp %h/%b", write_count, err_flags, m_count, m_err); end
  endtask

  task automatic test_readback();
    int p, l, ep;
    rd_ax = 4'd0; rd_ay = 3'd0;
    model_txn(4'd15, 3'd7, 1'b1, 1'b1, 5, 0, ep);
    do_txn(4'd15, 3'd7, 1'b1, 1'b1, 5, 0, p, l);
    @(posedge CLK); #1;
    rd_ax = 4'd15; rd_ay = 3'd7;
    @(negedge CLK);
    checks++; if (rd_on !== m_xpt[0]) begin failures++; $display("FAIL rd_before_edge: got %b exp %b", rd_on, m_xpt[0]); end
    @(negedge CLK);
    checks++; if (rd_on !== 1'b1) begin failures++; $display("FAIL rd_on_set: got %b exp 1", rd_on); end
    model_txn(4'd15, 3'd7, 1'b0, 1'b1, 5, 0, ep);
    do_txn(4'd15, 3'd7, 1'b0, 1'b1, 5, 0, p, l);
    checks++; if (rd_on !== 1'b0 || xpt_state[127] !== 1'b0) begin failures++; $display("FAIL rd_on_clr: got %b/%b exp 0/0", rd_on, xpt_state[127]); end
  endtask

  task automatic test_wrap();
    int p, l, ep;
    force dut.r_write_count = 16'hFFFF;
    @(posedge CLK); #1;
    release dut.r_write_count;
    m_count = 16'hFFFF;
    @(negedge CLK);
    checks++; if (write_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload: got %h exp ffff", write_count); end
    model_txn(4'd3, 3'd4, 1'b1, 1'b1, 4, 0, ep);
    do_txn(4'd3, 3'd4, 1'b1, 1'b1, 4, 0, p, l);
    checks++; if (write_count !== 16'h0000 || m_count !== 16'h0000) begin failures++; $display("FAIL wrap_count: got %h exp 0000", write_count); end
    checks++; if (p !== 1 || xpt_state !== m_xpt) begin failures++; $display("FAIL wrap_write: got p=%0d xpt=%h exp p=1 xpt=%h", p, xpt_state, m_xpt); end
  endtask

  task automatic test_reset_mid_strobe();
    int pulses;
    @(posedge CLK); #1;
    sw_ax = 4'd9; sw_ay = 3'd6; sw_data = 1'b1; sw_cs = 1'b1;
    @(posedge CLK); #1;
    sw_strobe = 1'b1;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 sw_strobe = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < SYNC + 6; k++) begin
      @(negedge CLK);
      if (upd_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || xpt_state !== 128'd0) begin failures++; $display("FAIL rstmid_nowrite: got p=%0d xpt=%h exp 0/0", pulses, xpt_state); end
    checks++; if (write_count !== 16'd0 || err_flags !== 3'b000 || rd_on !== 1'b0) begin failures++; $display("FAIL rstmid_outs: got %h/%b/%b exp 0/000/0", write_count, err_flags, rd_on); end
    checks++; if (upd_addr !== 7'd0 || upd_data !== 1'b0) begin failures++; $display("FAIL rstmid_upd: got %h/%b exp 0/0", upd_addr, upd_data); end
  endtask

  // Watchdog: every wait above is bounded, this only guards against a stall
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_write();
    test_short_strobe();
    test_cs_and_setup();
    test_random();
    test_sw_reset();
    test_readback();
    test_wrap();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
